// File: rtl/fsmd_pkg.sv
// rtl/fsmd_pkg.sv - schedule phases and operand indices shared with the FSM+D control unit
package fsmd_pkg;

    localparam logic [2:0] S0 = 3'd0;
    localparam logic [2:0] S1 = 3'd1;
    localparam logic [2:0] S2 = 3'd2;
    localparam logic [2:0] S3 = 3'd3;
    localparam logic [2:0] S4 = 3'd4;

    localparam int NUM_OPERANDS = 5;

    localparam int IDX_A = 0;
    localparam int IDX_B = 1;
    localparam int IDX_C = 2;
    localparam int IDX_D = 3;
    localparam int IDX_E = 4;

endpackage

// File: rtl/fsmd_phase_counter.sv
// rtl/fsmd_phase_counter.sv - mod-5 schedule counter in lock-step with the control unit S0..S4
module fsmd_phase_counter
    import fsmd_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    output logic [2:0] phase,
    output logic       wrap
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase <= S0;
        end else if (phase == S4) begin
            phase <= S0;
        end else begin
            phase <= phase + 3'd1;
        end
    end

    assign wrap = (phase == S4);

endmodule

// File: rtl/fsmd_operand_feeder.sv
// rtl/fsmd_operand_feeder.sv - nibble stream to shadow frame, committed to a..e at schedule boundary; option FSMD_FEEDER_ZERO_ON_EMPTY_EN
module fsmd_operand_feeder
    import fsmd_pkg::*;
#(
    parameter int W = 4
)
(
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] a,
    output logic [W-1:0] b,
    output logic [W-1:0] c,
    output logic [W-1:0] d,
    output logic [W-1:0] e,
    output logic [2:0]   phase,
    output logic         frame_valid,
    output logic         frame_start,
    output logic [7:0]   frame_count
);

    logic [W-1:0] shadow [NUM_OPERANDS];
    logic [2:0]   idx;
    logic         shadow_full;
    logic         wrap;
    logic         xfer;
    logic         commit;

    fsmd_phase_counter u_phase (
        .clock (clock),
        .reset (reset),
        .phase (phase),
        .wrap  (wrap)
    );

    assign in_ready = ~shadow_full;
    assign xfer     = in_valid && in_ready;
    // Decision uses shadow_full as held before the 4->0 edge, so a frame
    // completed in phase 4 waits for the next boundary.
    assign commit   = wrap && shadow_full;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idx         <= 3'(IDX_A);
            shadow_full <= 1'b0;
            for (int i = 0; i < NUM_OPERANDS; i++) begin
                shadow[i] <= '0;
            end
        end else if (xfer) begin
            for (int i = 0; i < NUM_OPERANDS; i++) begin
                if (idx == 3'(i)) begin
                    shadow[i] <= in_data;
                end
            end
            if (idx == 3'(IDX_E)) begin
                idx         <= 3'(IDX_A);
                shadow_full <= 1'b1;
            end else begin
                idx <= idx + 3'd1;
            end
        end else if (commit) begin
            shadow_full <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a           <= '0;
            b           <= '0;
            c           <= '0;
            d           <= '0;
            e           <= '0;
            frame_valid <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= 8'd0;
        end else begin
            frame_start <= commit;
            if (wrap) begin
                frame_valid <= shadow_full;
            end
            if (commit) begin
                a           <= shadow[IDX_A];
                b           <= shadow[IDX_B];
                c           <= shadow[IDX_C];
                d           <= shadow[IDX_D];
                e           <= shadow[IDX_E];
                frame_count <= frame_count + 8'd1;
            end
`ifdef FSMD_FEEDER_ZERO_ON_EMPTY_EN
            else if (wrap) begin
                a <= '0;
                b <= '0;
                c <= '0;
                d <= '0;
                e <= '0;
            end
`endif
        end
    end

endmodule
